// File: rtl/pkt_encoder.sv
// pkt_encoder: host-side packet builder for the UART packet FSM.
// Accepts a command (opcode + operand-word count), then emits the
// header {opcode, reserved, len LSB, len MSB} followed by the operand
// words MSB byte first, on a valid/ready byte stream. Every output is
// registered, so none of them depends combinationally on ready_i.
module pkt_encoder #(
    parameter int         MAX_WORDS = 16,
    parameter logic [7:0] RSVD_BYTE = 8'h00,
    // Legal opcodes; these mirror the ECHO/ADD/MUL/DIV codes of the parser.
    parameter logic [7:0] OP_ECHO   = 8'h01,
    parameter logic [7:0] OP_ADD    = 8'h02,
    parameter logic [7:0] OP_MUL    = 8'h03,
    parameter logic [7:0] OP_DIV    = 8'h04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_op_i,
    input  logic [7:0]  cmd_words_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic [31:0] word_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_H_OP   = 3'd1,
        S_H_RSV  = 3'd2,
        S_H_LSB  = 3'd3,
        S_H_MSB  = 3'd4,
        S_W_WAIT = 3'd5,
        S_W_SEND = 3'd6
    } state_t;

    localparam logic [7:0] MAX_W8 = 8'(MAX_WORDS);

    state_t      state;
    logic [15:0] len_q;       // total packet length, header included
    logic [7:0]  words_left;  // operand words still to be sent
    logic [1:0]  byte_cnt;    // byte index inside the current word
    logic [31:0] sreg;        // current word, top byte is on data_o

    logic        op_legal;
    logic        count_legal;
    logic [15:0] len_calc;

    assign op_legal    = (cmd_op_i == OP_ECHO) || (cmd_op_i == OP_ADD) ||
                         (cmd_op_i == OP_MUL)  || (cmd_op_i == OP_DIV);
    assign count_legal = (cmd_words_i <= MAX_W8);
    // LEN = 4 + 4*words; the multiply by 4 is just a two-bit shift.
    assign len_calc    = 16'd4 + {6'd0, cmd_words_i, 2'b00};
    assign state_o     = state;

    // Packet FSM: state, counters, datapath and all registered outputs.
    // NOTE: every assignment here is non-blocking so all registers update
    // together from pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            len_q        <= 16'd0;
            words_left   <= 8'd0;
            byte_cnt     <= 2'd0;
            sreg         <= 32'd0;
            cmd_ready_o  <= 1'b1;
            word_ready_o <= 1'b0;
            data_o       <= 8'd0;
            valid_o      <= 1'b0;
            busy_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            // err_o is a single-cycle pulse unless re-armed below.
            err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        if (!op_legal || !count_legal) begin
                            // Command is consumed but produces no bytes.
                            err_o <= 1'b1;
                        end else begin
                            len_q       <= len_calc;
                            words_left  <= cmd_words_i;
                            byte_cnt    <= 2'd0;
                            data_o      <= cmd_op_i;
                            valid_o     <= 1'b1;
                            cmd_ready_o <= 1'b0;
                            busy_o      <= 1'b1;
                            state       <= S_H_OP;
                        end
                    end
                end

                S_H_OP: begin
                    if (ready_i) begin
                        data_o <= RSVD_BYTE;
                        state  <= S_H_RSV;
                    end
                end

                S_H_RSV: begin
                    if (ready_i) begin
                        data_o <= len_q[7:0];
                        state  <= S_H_LSB;
                    end
                end

                S_H_LSB: begin
                    if (ready_i) begin
                        data_o <= len_q[15:8];
                        state  <= S_H_MSB;
                    end
                end

                S_H_MSB: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        data_o  <= 8'd0;
                        if (words_left != 8'd0) begin
                            word_ready_o <= 1'b1;
                            state        <= S_W_WAIT;
                        end else begin
                            cmd_ready_o <= 1'b1;
                            busy_o      <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end

                S_W_WAIT: begin
                    if (word_valid_i) begin
                        sreg         <= word_i;
                        data_o       <= word_i[31:24];
                        valid_o      <= 1'b1;
                        word_ready_o <= 1'b0;
                        byte_cnt     <= 2'd0;
                        state        <= S_W_SEND;
                    end
                end

                S_W_SEND: begin
                    if (ready_i) begin
                        sreg     <= {sreg[23:0], 8'h00};
                        data_o   <= sreg[23:16];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Last byte of this word has just been taken.
                            valid_o    <= 1'b0;
                            data_o     <= 8'd0;
                            words_left <= words_left - 8'd1;
                            if (words_left == 8'd1) begin
                                cmd_ready_o <= 1'b1;
                                busy_o      <= 1'b0;
                                state       <= S_IDLE;
                            end else begin
                                word_ready_o <= 1'b1;
                                state        <= S_W_WAIT;
                            end
                        end
                    end
                end

                default: begin
                    valid_o      <= 1'b0;
                    word_ready_o <= 1'b0;
                    cmd_ready_o  <= 1'b1;
                    busy_o       <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_encoder.sv
// Directed testbench for pkt_encoder: header/payload byte order, length
// field, rejects, back-pressure stability, mid-packet reset, max packet.
module tb_pkt_encoder;

    localparam logic [7:0] OP_ECHO = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h02;
    localparam logic [7:0] OP_MUL  = 8'h03;

    logic        clk;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_op_i;
    logic [7:0]  cmd_words_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [31:0] word_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        err_o;
    logic [2:0]  state_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wq[$];     // operand words to feed
    logic [7:0]  exp_b[$];  // expected byte stream
    bit          wr_seen;   // word_ready_o observed during last collect
    int          cyc;

    pkt_encoder #(.MAX_WORDS(16), .RSVD_BYTE(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_words_i  (cmd_words_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .word_i       (word_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a command for one cycle; called on a negedge, returns on the next.
    task automatic send_cmd(input logic [7:0] op, input logic [7:0] words);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_words_i = words;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    // Stream bytes until n_exp have been taken, feeding words from wq.
    task automatic collect(input string name, input int n_exp, input bit rnd, output int cycles);
        int          got = 0;
        int          widx = 0;
        bit          stall = 1'b0;
        bit          take;
        logic [7:0]  prev_d = 8'd0;
        cycles  = 0;
        wr_seen = 1'b0;
        word_valid_i = (wq.size() > 0);
        word_i       = (wq.size() > 0) ? wq[0] : 32'd0;
        while (got < n_exp && cycles < 1000) begin
            if (stall) begin
                check($sformatf("%s_hold_valid", name), 32'(valid_o), 32'd1);
                check($sformatf("%s_hold_data", name), 32'(data_o), 32'(prev_d));
            end
            ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_seen = wr_seen | word_ready_o;
            take    = word_ready_o && word_valid_i;
            if (valid_o && ready_i) begin
                check($sformatf("%s_b%0d", name, got), 32'(data_o), 32'(exp_b[got]));
                got++;
            end
            stall  = valid_o && !ready_i;
            prev_d = data_o;
            @(negedge clk);
            cycles++;
            if (take) begin
                widx++;
                word_valid_i = (widx < wq.size());
                word_i       = (widx < wq.size()) ? wq[widx] : 32'd0;
            end
        end
        ready_i      = 1'b1;
        word_valid_i = 1'b0;
        check($sformatf("%s_count", name), 32'(got), 32'(n_exp));
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_op_i     = 8'd0;
        cmd_words_i  = 8'd0;
        word_valid_i = 1'b0;
        word_i       = 32'd0;
        ready_i      = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_word_ready", 32'(word_ready_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ADD, two words, ready held high: 4 + 5*2 = 14 streaming cycles.
        wq = '{32'h0000_0003, 32'h0000_0005};
        exp_b = '{8'h02, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03,
                  8'h00, 8'h00, 8'h00, 8'h05};
        send_cmd(OP_ADD, 8'd2);
        check("add_first_valid", 32'(valid_o), 32'd1);
        check("add_busy", 32'(busy_o), 32'd1);
        check("add_cmd_ready_low", 32'(cmd_ready_o), 32'd0);
        collect("add", 12, 1'b0, cyc);
        check("add_cycles", 32'(cyc), 32'd14);
        check("add_busy_fall", 32'(busy_o), 32'd0);
        check("add_valid_fall", 32'(valid_o), 32'd0);
        check("add_idle", 32'(state_o), 32'd0);

        // ECHO, zero words: header only, no word handshake.
        wq = {};
        exp_b = '{8'h01, 8'h00, 8'h04, 8'h00};
        send_cmd(OP_ECHO, 8'd0);
        collect("echo0", 4, 1'b0, cyc);
        check("echo0_cycles", 32'(cyc), 32'd4);
        check("echo0_no_wready", 32'(wr_seen), 32'd0);
        check("echo0_idle", 32'(state_o), 32'd0);
        check("echo0_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Word count MAX_WORDS+1 is rejected.
        send_cmd(OP_ADD, 8'd17);
        check("len_err_pulse", 32'(err_o), 32'd1);
        check("len_err_valid", 32'(valid_o), 32'd0);
        check("len_err_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("len_err_state", 32'(state_o), 32'd0);
        @(negedge clk);
        check("len_err_one_cycle", 32'(err_o), 32'd0);
        check("len_err_valid2", 32'(valid_o), 32'd0);

        // Illegal opcode is rejected.
        send_cmd(8'hFF, 8'd1);
        check("op_err_pulse", 32'(err_o), 32'd1);
        check("op_err_valid", 32'(valid_o), 32'd0);
        check("op_err_cmd_ready", 32'(cmd_ready_o), 32'd1);
        @(negedge clk);
        check("op_err_one_cycle", 32'(err_o), 32'd0);

        // MUL, one word, random back-pressure; stalled bytes must hold.
        wq = '{32'hDEAD_BEEF};
        exp_b = '{8'h03, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_cmd(OP_MUL, 8'd1);
        collect("mul_bp", 8, 1'b1, cyc);
        check("mul_bp_idle", 32'(state_o), 32'd0);
        check("mul_bp_busy", 32'(busy_o), 32'd0);

        // Reset while payload byte 2 is pending.
        wq = '{32'h1122_3344};
        exp_b = '{8'h02, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22};
        send_cmd(OP_ADD, 8'd1);
        collect("pre_rst", 6, 1'b0, cyc);
        check("pre_rst_pending_valid", 32'(valid_o), 32'd1);
        check("pre_rst_pending_data", 32'(data_o), 32'h33);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_no_resume", 32'(valid_o), 32'd0);
        wq = {};
        exp_b = '{8'h01, 8'h00, 8'h04, 8'h00};
        send_cmd(OP_ECHO, 8'd0);
        collect("post_rst", 4, 1'b0, cyc);

        // MAX_WORDS packet: LEN = 68 = 0x0044, then back-to-back command.
        wq = {};
        exp_b = '{8'h02, 8'h00, 8'h44, 8'h00};
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            w = {8'(i), 8'hA5, 8'(i + 1), 8'h5A};
            wq.push_back(w);
            exp_b.push_back(w[31:24]);
            exp_b.push_back(w[23:16]);
            exp_b.push_back(w[15:8]);
            exp_b.push_back(w[7:0]);
        end
        send_cmd(OP_ADD, 8'd16);
        collect("max", 68, 1'b0, cyc);
        check("max_cycles", 32'(cyc), 32'd84);
        check("b2b_cmd_ready", 32'(cmd_ready_o), 32'd1);
        wq = {};
        exp_b = '{8'h01, 8'h00, 8'h04, 8'h00};
        send_cmd(OP_ECHO, 8'd0);
        check("b2b_valid", 32'(valid_o), 32'd1);
        check("b2b_op", 32'(data_o), 32'(OP_ECHO));
        collect("b2b", 4, 1'b0, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
